bp_btb: RTL and testbench

//  Branch target buffer for the fetch stage, sitting beside the global-history

---
 rtl/bp_btb_if.sv | 31 +++
 rtl/bp_btb.sv | 68 ++++++
 tb/tb_bp_btb.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bp_btb_if.sv
// Fetch/M-stage signal bundle between the datapath and the branch target buffer.
// branchM qualifies the M-stage fields; there is no backpressure, every presented cycle is consumed.
interface bp_btb_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 pcsrcPF;
  logic [31:0]          pcF;
  logic                 hitF;
  logic [31:0]          targetF;
  logic                 pred_takenF;
  logic [31:0]          npc_predF;
  logic                 branchM;
  logic [31:0]          pcM;
  logic                 pcsrcM;
  logic [31:0]          branch_targetM;
  logic                 pred_takenM;
  logic [31:0]          pred_targetM;
  logic                 redirectM;
  logic [31:0]          redirect_pcM;
  logic [CNT_WIDTH-1:0] redirect_cnt;

  modport master (
    output pcF, pcsrcPF, branchM, pcM, pcsrcM, branch_targetM, pred_takenM, pred_targetM,
    input  hitF, targetF, pred_takenF, npc_predF, redirectM, redirect_pcM, redirect_cnt
  );

  modport slave (
    input  pcF, pcsrcPF, branchM, pcM, pcsrcM, branch_targetM, pred_takenM, pred_targetM,
    output hitF, targetF, pred_takenF, npc_predF, redirectM, redirect_pcM, redirect_cnt
  );
endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: zero-latency fetch lookup, M-stage training
// on taken branches, and mispredict redirect with a saturating redirect counter.
module bp_btb #(
  parameter int BTB_DEPTH = 6,
  parameter int TAG_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  bp_btb_if.slave  bus
);
  localparam int ENTRIES = 1 << BTB_DEPTH;

  logic [ENTRIES-1:0]   validQ;
  logic [TAG_WIDTH-1:0] tagQ    [ENTRIES];
  logic [31:0]          targetQ [ENTRIES];
  logic [CNT_WIDTH-1:0] cntQ;

  logic [BTB_DEPTH-1:0] idxF, idxM;
  logic [TAG_WIDTH-1:0] tagF, tagM;
  logic                 hit;
  logic                 predTaken;
  logic                 redirect;
  logic                 update;

  assign idxF = bus.pcF[BTB_DEPTH+1:2];
  assign tagF = bus.pcF[BTB_DEPTH+TAG_WIDTH+1:BTB_DEPTH+2];
  assign idxM = bus.pcM[BTB_DEPTH+1:2];
  assign tagM = bus.pcM[BTB_DEPTH+TAG_WIDTH+1:BTB_DEPTH+2];

  // Lookup reads the registered arrays directly, so a same-cycle write is seen next cycle.
  assign hit       = !rst && validQ[idxF] && (tagQ[idxF] == tagF);
  assign predTaken = hit && bus.pcsrcPF;

  assign bus.hitF        = hit;
  assign bus.targetF     = hit ? targetQ[idxF] : 32'd0;
  assign bus.pred_takenF = predTaken;
  assign bus.npc_predF   = predTaken ? targetQ[idxF] : bus.pcF + 32'd4;

  assign redirect = bus.branchM &&
                    ((bus.pcsrcM != bus.pred_takenM) ||
                     (bus.pcsrcM && (bus.pred_targetM != bus.branch_targetM)));

  assign bus.redirectM    = redirect;
  assign bus.redirect_pcM = !redirect ? 32'd0 :
                            bus.pcsrcM ? bus.branch_targetM : bus.pcM + 32'd4;
  assign bus.redirect_cnt = cntQ;

  // Only taken branches train; direction belongs to the global predictor.
  assign update = !rst && bus.branchM && bus.pcsrcM;

  always_ff @(posedge clk) begin
    if (rst) begin
      validQ <= '0;
      cntQ   <= '0;
    end else begin
      if (update) validQ[idxM] <= 1'b1;
      if (redirect && (cntQ != '1)) cntQ <= cntQ + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (update) begin
      tagQ[idxM]    <= tagM;
      targetQ[idxM] <= bus.branch_targetM;
    end
  end
endmodule

// File: tb/tb_bp_btb.sv
// Directed bench for bp_btb: lookup, training, aliasing, same-cycle update,
// redirect cases, PC wrap, reset discard, and counter saturation (second instance).
module tb_bp_btb;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bp_btb_if #(.CNT_WIDTH(16)) bus  ();
  bp_btb_if #(.CNT_WIDTH(2))  bus2 ();

  bp_btb #(.BTB_DEPTH(6), .TAG_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  bp_btb #(.BTB_DEPTH(6), .TAG_WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic br, input logic [31:0] pc, input logic taken,
                         input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
    bus.branchM        = br;
    bus.pcM            = pc;
    bus.pcsrcM         = taken;
    bus.branch_targetM = tgt;
    bus.pred_takenM    = ptaken;
    bus.pred_targetM   = ptgt;
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic dir);
    bus.pcF     = pc;
    bus.pcsrcPF = dir;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.pcF = '0; bus.pcsrcPF = 1'b0;
    drive_m(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    bus2.pcF = '0; bus2.pcsrcPF = 1'b0; bus2.branchM = 1'b0; bus2.pcM = '0;
    bus2.pcsrcM = 1'b0; bus2.branch_targetM = '0; bus2.pred_takenM = 1'b0; bus2.pred_targetM = '0;
    step();
    step();

    // Reset-time lookup
    lookup(32'h0040_0000, 1'b1);
    check("rst_hit", {31'd0, bus.hitF}, 32'd0);
    check("rst_ptaken", {31'd0, bus.pred_takenF}, 32'd0);
    check("rst_npc", bus.npc_predF, 32'h0040_0004);
    rst = 1'b0;
    step();
    check("post_rst_cnt", {16'd0, bus.redirect_cnt}, 32'd0);
    check("post_rst_hit", {31'd0, bus.hitF}, 32'd0);
    check("post_rst_target", bus.targetF, 32'd0);
    check("post_rst_npc", bus.npc_predF, 32'h0040_0004);

    // First taken branch: mispredicted direction, trains the entry
    drive_m(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    check("t2_redirect", {31'd0, bus.redirectM}, 32'd1);
    check("t2_redirect_pc", bus.redirect_pcM, 32'h0040_0100);
    step();
    drive_m(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("t2_cnt", {16'd0, bus.redirect_cnt}, 32'd1);
    check("t2_idle_redirect_pc", bus.redirect_pcM, 32'd0);
    lookup(32'h0040_0010, 1'b1);
    check("t2_hit", {31'd0, bus.hitF}, 32'd1);
    check("t2_target", bus.targetF, 32'h0040_0100);
    check("t2_ptaken", {31'd0, bus.pred_takenF}, 32'd1);
    check("t2_npc", bus.npc_predF, 32'h0040_0100);
    lookup(32'h0040_0010, 1'b0);
    check("t2_nt_ptaken", {31'd0, bus.pred_takenF}, 32'd0);
    check("t2_nt_npc", bus.npc_predF, 32'h0040_0014);
    lookup(32'h0040_0013, 1'b1);
    check("t2_lowbits_hit", {31'd0, bus.hitF}, 32'd1);

    // Aliasing: same index 4, tag 0x40 replaces tag 0x00
    drive_m(1'b1, 32'h0040_4010, 1'b1, 32'h0000_0200, 1'b0, 32'h0040_4014);
    step();
    drive_m(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("t3_cnt", {16'd0, bus.redirect_cnt}, 32'd2);
    lookup(32'h0040_0010, 1'b1);
    check("t3_old_miss", {31'd0, bus.hitF}, 32'd0);
    check("t3_old_target", bus.targetF, 32'd0);
    lookup(32'h0040_4010, 1'b1);
    check("t3_new_hit", {31'd0, bus.hitF}, 32'd1);
    check("t3_new_target", bus.targetF, 32'h0000_0200);

    // Same-cycle update and lookup of index 4: old contents this cycle
    lookup(32'h0040_0010, 1'b1);
    drive_m(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    check("t4_same_cycle_hit", {31'd0, bus.hitF}, 32'd0);
    check("t4_same_cycle_npc", bus.npc_predF, 32'h0040_0014);
    step();
    drive_m(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("t4_next_hit", {31'd0, bus.hitF}, 32'd1);
    check("t4_next_target", bus.targetF, 32'h0040_0100);
    check("t4_cnt", {16'd0, bus.redirect_cnt}, 32'd3);

    // Not-taken resolution after predicted taken: redirect to fall-through, entry kept
    drive_m(1'b1, 32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
    check("t4_nt_redirect", {31'd0, bus.redirectM}, 32'd1);
    check("t4_nt_redirect_pc", bus.redirect_pcM, 32'h0040_0014);
    step();
    drive_m(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("t4_nt_cnt", {16'd0, bus.redirect_cnt}, 32'd4);
    check("t4_nt_kept_hit", {31'd0, bus.hitF}, 32'd1);
    check("t4_nt_kept_target", bus.targetF, 32'h0040_0100);

    // Target mismatch with correct direction
    drive_m(1'b1, 32'h0040_0020, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0300);
    check("t5_tgt_redirect", {31'd0, bus.redirectM}, 32'd1);
    check("t5_tgt_redirect_pc", bus.redirect_pcM, 32'h0000_0400);
    step();
    check("t5_tgt_cnt", {16'd0, bus.redirect_cnt}, 32'd5);

    // Correct taken prediction: no redirect, counter holds
    drive_m(1'b1, 32'h0040_0020, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0400);
    check("t5_ok_redirect", {31'd0, bus.redirectM}, 32'd0);
    check("t5_ok_redirect_pc", bus.redirect_pcM, 32'd0);
    step();
    check("t5_ok_cnt", {16'd0, bus.redirect_cnt}, 32'd5);

    // Correct not-taken prediction; then no branch with mismatching fields
    drive_m(1'b1, 32'h0040_0030, 1'b0, 32'h0000_0500, 1'b0, 32'h0040_0034);
    check("t5_nt_ok_redirect", {31'd0, bus.redirectM}, 32'd0);
    drive_m(1'b0, 32'h0040_0030, 1'b1, 32'h0000_0500, 1'b0, 32'h0000_0000);
    check("t5_nobranch_redirect", {31'd0, bus.redirectM}, 32'd0);
    step();
    check("t5_nobranch_cnt", {16'd0, bus.redirect_cnt}, 32'd5);

    // PC wrap on both the fetch and redirect paths
    lookup(32'hFFFF_FFFC, 1'b1);
    check("wrap_hit", {31'd0, bus.hitF}, 32'd0);
    check("wrap_npc", bus.npc_predF, 32'h0000_0000);
    drive_m(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_1000, 1'b1, 32'h0000_1000);
    check("wrap_redirect", {31'd0, bus.redirectM}, 32'd1);
    check("wrap_redirect_pc", bus.redirect_pcM, 32'h0000_0000);
    step();
    drive_m(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("wrap_cnt", {16'd0, bus.redirect_cnt}, 32'd6);

    // Reset with a taken update pending: update discarded, redirect stays combinational
    lookup(32'h0040_0010, 1'b1);
    rst = 1'b1;
    drive_m(1'b1, 32'h0040_0040, 1'b1, 32'h0040_0500, 1'b0, 32'h0040_0044);
    check("t6_rst_hit", {31'd0, bus.hitF}, 32'd0);
    check("t6_rst_npc", bus.npc_predF, 32'h0040_0014);
    check("t6_rst_redirect", {31'd0, bus.redirectM}, 32'd1);
    check("t6_rst_redirect_pc", bus.redirect_pcM, 32'h0040_0500);
    step();
    rst = 1'b0;
    drive_m(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("t6_cnt", {16'd0, bus.redirect_cnt}, 32'd0);
    lookup(32'h0040_0040, 1'b1);
    check("t6_discard_hit", {31'd0, bus.hitF}, 32'd0);
    lookup(32'h0040_0010, 1'b1);
    check("t6_cleared_hit", {31'd0, bus.hitF}, 32'd0);
    lookup(32'h0040_0020, 1'b1);
    check("t6_cleared_hit2", {31'd0, bus.hitF}, 32'd0);

    // Saturation on the 2-bit counter instance: 1,2,3,3,3
    bus2.branchM = 1'b1; bus2.pcM = 32'h0000_0040; bus2.pcsrcM = 1'b1;
    bus2.branch_targetM = 32'h0000_0100; bus2.pred_takenM = 1'b0; bus2.pred_targetM = 32'h0000_0044;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("sat_cnt_%0d", i), {30'd0, bus2.redirect_cnt}, (i < 3) ? (i + 1) : 3);
    end
    bus2.branchM = 1'b0;
    step();
    check("sat_hold", {30'd0, bus2.redirect_cnt}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
